// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_core
// Function : UART transmitter with a one-entry holding register. Frames are
//            start + DATA_BITS (LSB first) + optional parity + STOP_BITS,
//            with every bit boundary aligned to baud_tick. A byte waiting in
//            the holding register follows the previous frame with no gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
  parameter int DATA_BITS  = 8,  // 5..8
  parameter int PARITY_EN  = 0,  // 1 = append a parity bit
  parameter int PARITY_ODD = 0,  // 0 = even, 1 = odd (when PARITY_EN = 1)
  parameter int STOP_BITS  = 1   // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(DATA_BITS - 1);
  localparam logic             c_stop_last  = (STOP_BITS == 2);
  localparam logic             c_parity_en  = (PARITY_EN != 0);
  localparam logic             c_parity_odd = (PARITY_ODD != 0);

  logic [2:0]           r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stop_cnt;
  logic                 r_parity;
  logic                 r_tx;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;

  logic w_accept;
  logic w_stop_end;
  logic w_load;

  // The holding register is only writable while empty, so an accept and a
  // load can never fall on the same edge; the ordering below still lets a
  // new byte win over the clear if that ever changed.
  assign w_accept   = tx_valid & ~r_hold_full;
  assign w_stop_end = (r_state == c_st_stop) && (r_stop_cnt == c_stop_last);
  assign w_load     = baud_tick & r_hold_full &
                      ((r_state == c_st_idle) | w_stop_end);

  assign tx_ready = ~r_hold_full;
  assign tx       = r_tx;
  assign tx_busy  = (r_state != c_st_idle) | r_hold_full;

  // Holding register: filled by the handshake, emptied when the shifter loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  // Frame sequencer: tx is registered and set on the edge entering each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_shift    <= '0;
      r_idx      <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
    end else if (w_load) begin
      // Parity is taken from the byte being latched, so later writes to the
      // holding register cannot disturb the frame in flight.
      r_state  <= c_st_start;
      r_shift  <= r_hold;
      r_parity <= (^r_hold) ^ c_parity_odd;
      r_tx     <= 1'b0;
    end else if (baud_tick) begin
      case (r_state)
        c_st_idle: begin
          r_tx <= 1'b1;
        end
        c_st_start: begin
          r_state <= c_st_data;
          r_idx   <= '0;
          r_tx    <= r_shift[0];
        end
        c_st_data: begin
          if (r_idx == c_last_idx) begin
            if (c_parity_en) begin
              r_state <= c_st_parity;
              r_tx    <= r_parity;
            end else begin
              r_state    <= c_st_stop;
              r_stop_cnt <= 1'b0;
              r_tx       <= 1'b1;
            end
          end else begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 1'b1;
            r_tx    <= r_shift[1];
          end
        end
        c_st_parity: begin
          r_state    <= c_st_stop;
          r_stop_cnt <= 1'b0;
          r_tx       <= 1'b1;
        end
        c_st_stop: begin
          if (r_stop_cnt == c_stop_last) begin
            r_state <= c_st_idle;
            r_tx    <= 1'b1;
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
